// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, the bubble encoding and the fetch FSM states.
package cpu_pkg;

  localparam int PC_W = 10;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Next-fetch program counter: holds, advances by one word, or loads a redirect target.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4
);

  // Wraps naturally modulo 2^PC_W.
  assign pc_plus4 = pc + PC_W'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (en) begin
      pc <= load ? target : pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request/ack instruction-memory handshake, one-entry skid buffer
// for decode stalls, and redirect handling that drains a stale in-flight request.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] instruction,
  output logic               fetch_valid,
  output logic               flush
);

  fetch_state_t       state;
  logic               req_reg;
  logic               ack_valid;
  logic               pc_en;
  logic               pc_load;
  logic [PC_W-1:0]    pc_target;
  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    fetch_pc_plus4;
  logic [PC_W-1:0]    drain_addr;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_data;

  assign ack_valid = imem_ack && req_reg;
  assign pc_target = branch_target & ~PC_W'(3);

  always_comb begin
    pc_en   = branch_taken || ((state == ST_REQ) && ack_valid);
    pc_load = branch_taken;
  end

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .en       (pc_en),
    .load     (pc_load),
    .target   (pc_target),
    .pc       (fetch_pc),
    .pc_plus4 (fetch_pc_plus4)
  );

  // While draining, the old address must stay on the bus even though fetch_pc already points at the target.
  assign imem_req  = req_reg;
  assign imem_addr = (state == ST_DRAIN) ? drain_addr : fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_REQ;
      req_reg     <= 1'b0;
      PC          <= '0;
      instruction <= NOP_INSTR;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= NOP_INSTR;
      drain_addr  <= RESET_PC;
    end else begin
      flush <= branch_taken;
      if (branch_taken) begin
        skid_valid  <= 1'b0;
        instruction <= NOP_INSTR;
        fetch_valid <= 1'b0;
        req_reg     <= 1'b1;
        if ((state != ST_HOLD) && req_reg && !imem_ack) begin
          state <= ST_DRAIN;
          if (state == ST_REQ) begin
            drain_addr <= fetch_pc;
          end
        end else begin
          state <= ST_REQ;
        end
      end else begin
        case (state)
          ST_REQ: begin
            req_reg <= 1'b1;
            if (ack_valid) begin
              if (stall) begin
                skid_valid <= 1'b1;
                skid_data  <= imem_rdata;
                state      <= ST_HOLD;
                req_reg    <= 1'b0;
              end else begin
                instruction <= imem_rdata;
                PC          <= fetch_pc_plus4;
                fetch_valid <= 1'b1;
              end
            end else if (!stall) begin
              instruction <= NOP_INSTR;
              fetch_valid <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              // fetch_pc already sits one word past the skid entry, which is its PC+4.
              if (skid_valid) begin
                instruction <= skid_data;
                PC          <= fetch_pc;
                fetch_valid <= 1'b1;
              end else begin
                instruction <= NOP_INSTR;
                fetch_valid <= 1'b0;
              end
              skid_valid <= 1'b0;
              state      <= ST_REQ;
              req_reg    <= 1'b1;
            end
          end
          ST_DRAIN: begin
            instruction <= NOP_INSTR;
            fetch_valid <= 1'b0;
            req_reg     <= 1'b1;
            if (ack_valid) begin
              state <= ST_REQ;
            end
          end
          default: begin
            state   <= ST_REQ;
            req_reg <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, default 10, PC/address width in bits (byte address, word-aligned).
REQ-002 Parameter: RESET_PC, default 10'h000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 stall  input  1  decode-side hold request from hazard unit.
REQ-006 branch_taken  input  1  redirect request, sampled each posedge.
REQ-007 branch_target  input  PC_W  redirect address, valid when branch_taken=1.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  PC_W  instruction-memory address.
REQ-010 imem_ack  input  1  memory completion; rdata valid same cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 PC  output  PC_W  fetch address + 4 of the presented instruction, to the IF/ID register PC input.
REQ-013 instruction  output  32  presented instruction, to the IF/ID register instruction input; 32'b0 = bubble.
REQ-014 fetch_valid  output  1  instruction/PC carry a real fetched word this cycle.
REQ-015 flush  output  1  one-cycle pulse to the IF/ID register flush input.

Function
REQ-016 States: REQ (request outstanding), HOLD (stalled, no request), DRAIN (discarding a stale outstanding request).
REQ-017 Handshake: once imem_req=1, imem_req and imem_addr stay constant until the cycle imem_ack=1; imem_ack with imem_req=0 is ignored.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc; on ack with no stall/branch: instruction<=imem_rdata, PC<=fetch_pc+4, fetch_valid<=1, fetch_pc<=fetch_pc+4, stay REQ with new request next cycle.
REQ-019 REQ without ack: instruction<=32'b0, fetch_valid<=0, PC unchanged.
REQ-020 PC arithmetic modulo 2^PC_W: address 10'h3FC + 4 wraps to 10'h000; branch_target[1:0] ignored (forced 2'b00).
REQ-021 stall=1 in REQ without ack: stay REQ (handshake rule), outputs held.
REQ-022 stall=1 in REQ with ack: word captured into one-entry skid buffer, fetch_pc advances, go HOLD, outputs held.
REQ-023 HOLD: imem_req=0, outputs held; on stall=0 present skid entry (if any) with fetch_valid=1 then return to REQ; skid entry never re-fetched from memory.
REQ-024 branch_taken=1: flush=1 next cycle for exactly one cycle; fetch_pc<=branch_target; skid buffer cleared.
REQ-025 Branch in REQ with ack same cycle: rdata discarded, next state REQ at target.
REQ-026 Branch in REQ without ack: go DRAIN; imem_req held on old address until ack; acked data discarded; then REQ at target.
REQ-027 Branch in HOLD: go REQ at target regardless of stall.
REQ-028 Branch in DRAIN: target overwritten by newest branch_target; flush pulses again.
REQ-029 Priority: branch_taken > stall > normal advance.
REQ-030 Throughput: single-cycle-ack memory sustains one instruction per cycle; latency request->presented = 1 cycle.

Reset
REQ-031 rst=1 asynchronously forces: state REQ, fetch_pc=RESET_PC, PC=0, instruction=32'b0, fetch_valid=0, flush=0, skid empty, imem_req=0.
REQ-032 First request issued the first cycle after rst deasserts; reset mid-request abandons it without ack wait.

Structure
REQ-033 Shared package cpu_pkg holds PC_W, INSTR_W=32, NOP_INSTR=32'b0, and the fetch state enum.
REQ-034 One sub-module fetch_pc_reg: PC register with increment-by-4, redirect load, and hold enable.

Verification
REQ-035 Reset release, ack every cycle, rdata 0x11,0x22,0x33 -> imem_addr 0x000,0x004,0x008; PC 0x004,0x008,0x00C; fetch_valid=1 each cycle.
REQ-036 Ack delayed 3 cycles at addr 0x010 -> imem_addr stable 0x010 for 4 cycles; instruction=0, fetch_valid=0 until ack.
REQ-037 stall=1 in ack cycle at 0x020 -> HOLD, imem_req=0; stall drop after 2 cycles -> skid word presented with PC 0x024, next request 0x024.
REQ-038 branch_taken=1, target 0x100, while request at 0x030 pending -> flush pulse 1 cycle, stale data discarded, next request 0x100.
REQ-039 branch_taken and stall same cycle, target 0x3FC -> flush=1, request 0x3FC, following request 0x000 (wrap).
REQ-040 rst asserted mid-DRAIN -> outputs zero immediately, next request RESET_PC after release.
